// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;

  localparam int STAT_W   = 16;
  localparam int MAX_NREQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_res_t;

  // First requester at or above ptr, wrapping at nreq.
  function automatic rr_res_t next_rr(input logic [2:0] ptr,
                                      input logic [MAX_NREQ-1:0] req,
                                      input int nreq);
    rr_res_t res;
    int      k;
    res = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      k = (int'(ptr) + i) % nreq;
      if (i < nreq && !res.found && req[3'(k)]) begin
        res.found = 1'b1;
        res.idx   = 3'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: request vector + start pointer
// to one-hot grant and index. Shared with the pop-side scheduler.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt_oh,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    found
);

  localparam int IW = $clog2(NREQ);

  rr_res_t res;

  always_comb begin
    res     = next_rr(3'(ptr), 8'(req), NREQ);
    found   = res.found;
    gnt_idx = IW'(res.idx);
    gnt_oh  = '0;
    if (res.found) gnt_oh[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among NREQ producers.
// Define FIFO_ARB_STATS_EN to add per-producer accept counters and a stall counter.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      wdata,
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    fifo_push,
  output logic [DW-1:0]           fifo_din,
  input  logic                    fifo_full,
  input  logic                    fifo_a_full
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic [$clog2(NREQ)-1:0] stat_sel,
  input  logic                    stat_clr,
  output logic [STAT_W-1:0]       stat_cnt,
  output logic [STAT_W-1:0]       stall_cnt
`endif
);

  localparam int              IW         = $clog2(NREQ);
  localparam logic [3:0]      BURST_LAST = 4'(MAX_BURST - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [3:0]    burst_cnt_q, burst_cnt_d;
  logic          busy_q, busy_d;
  logic          fifo_push_q, fifo_push_d;
  logic [DW-1:0] fifo_din_q, fifo_din_d;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_found;
  logic            can_accept, win_valid, accept;
  logic [IW-1:0]   winner;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(NREQ - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .found   (pick_found)
  );

  // A push already in flight will consume the last free entry.
  always_comb begin
    can_accept = !fifo_full && !(fifo_push_q && fifo_a_full);
    if (state_q == BURST) begin
      winner    = grant_id_q;
      win_valid = req[grant_id_q];
    end else begin
      winner    = pick_idx;
      win_valid = pick_found;
    end
    accept = can_accept && win_valid;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_id_d = winner;
          if (MAX_BURST == 1) begin
            rr_ptr_d = ptr_inc(winner);
          end else begin
            state_d     = BURST;
            burst_cnt_d = 4'd1;
          end
        end
      end
      BURST: begin
        if (accept) begin
          if (burst_cnt_q == BURST_LAST) begin
            state_d     = IDLE;
            rr_ptr_d    = ptr_inc(grant_id_q);
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end else if (!req[grant_id_q]) begin
          state_d     = IDLE;
          rr_ptr_d    = ptr_inc(grant_id_q);
          burst_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d == BURST);
    fifo_push_d = accept;
    fifo_din_d  = accept ? wdata[winner*DW +: DW] : fifo_din_q;
  end

  always_comb begin
    ack = '0;
    if (accept) begin
      if (state_q == BURST) ack[winner] = 1'b1;
      else                  ack = pick_oh;
    end
    grant_id  = grant_id_q;
    busy      = busy_q;
    fifo_push = fifo_push_q;
    fifo_din  = fifo_din_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      busy_q      <= 1'b0;
      fifo_push_q <= 1'b0;
      fifo_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      busy_q      <= busy_d;
      fifo_push_q <= fifo_push_d;
      fifo_din_q  <= fifo_din_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] acc_cnt_q [NREQ];
  logic [STAT_W-1:0] acc_cnt_d [NREQ];
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters; a clear beats a same-cycle increment.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      acc_cnt_d[k] = acc_cnt_q[k];
      if (stat_clr)                         acc_cnt_d[k] = '0;
      else if (ack[k] && acc_cnt_q[k] != '1) acc_cnt_d[k] = acc_cnt_q[k] + 1'b1;
    end
    stall_cnt_d = stall_cnt_q;
    if (stat_clr)                                          stall_cnt_d = '0;
    else if ((|req) && !can_accept && stall_cnt_q != '1)   stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREQ; k++) acc_cnt_q[k] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) acc_cnt_q[k] <= acc_cnt_d[k];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_cnt  = acc_cnt_q[stat_sel];
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter: one MAX_BURST=1 instance and one MAX_BURST=4
// instance fed by a small FIFO occupancy model.
module tb_fifo_push_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // MAX_BURST = 1 instance, FIFO never full
  logic [3:0]  req1, ack1;
  logic [31:0] wdata1;
  logic [1:0]  gid1;
  logic        busy1, push1;
  logic [7:0]  din1;

  // MAX_BURST = 4 instance with FIFO model
  logic [3:0]  req4, ack4;
  logic [31:0] wdata4;
  logic [1:0]  gid4;
  logic        busy4, push4, full4, afull4, pop4, model_on;
  logic [7:0]  din4;
  int          fifo_cnt4;

`ifdef FIFO_ARB_STATS_EN
  logic [1:0]  stat_sel1, stat_sel4;
  logic        stat_clr1, stat_clr4;
  logic [15:0] stat_cnt1, stall_cnt1, stat_cnt4, stall_cnt4;
`endif

  int burst_p [12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};

  assign full4  = model_on && (fifo_cnt4 >= 4);
  assign afull4 = model_on && (fifo_cnt4 == 3);

  always @(posedge clk) begin
    if (rst) fifo_cnt4 <= 0;
    else     fifo_cnt4 <= fifo_cnt4 + (push4 ? 1 : 0) - ((pop4 && fifo_cnt4 > 0) ? 1 : 0);
  end

  fifo_push_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .wdata(wdata1), .ack(ack1), .grant_id(gid1),
    .busy(busy1), .fifo_push(push1), .fifo_din(din1), .fifo_full(1'b0), .fifo_a_full(1'b0)
`ifdef FIFO_ARB_STATS_EN
    , .stat_sel(stat_sel1), .stat_clr(stat_clr1), .stat_cnt(stat_cnt1), .stall_cnt(stall_cnt1)
`endif
  );

  fifo_push_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .wdata(wdata4), .ack(ack4), .grant_id(gid4),
    .busy(busy4), .fifo_push(push4), .fifo_din(din4), .fifo_full(full4), .fifo_a_full(afull4)
`ifdef FIFO_ARB_STATS_EN
    , .stat_sel(stat_sel4), .stat_clr(stat_clr4), .stat_cnt(stat_cnt4), .stall_cnt(stall_cnt4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n0, n1, n2, pushes, p;
    logic [7:0] exp_d;

    rst = 1'b1; req1 = '0; req4 = '0; wdata1 = '0; wdata4 = '0;
    pop4 = 1'b0; model_on = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    stat_sel1 = '0; stat_sel4 = '0; stat_clr1 = 1'b0; stat_clr4 = 1'b0;
`endif
    repeat (3) step();
    rst = 1'b0;

    // Reset state held while idle
    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_push1", push1, 0); check("rst_ack1", ack1, 0);
      check("rst_busy1", busy1, 0); check("rst_gid1", gid1, 0);
      check("rst_push4", push4, 0); check("rst_ack4", ack4, 0);
      check("rst_busy4", busy4, 0); check("rst_gid4", gid4, 0);
      check("rst_din4", din4, 0);
    end

    // Round-robin, MAX_BURST=1: two full rotations
    wdata1 = 32'h40302010;
    req1   = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_ack", ack1, 32'(1 << (i % 4)));
      step();
      check("rr_push", push1, 1);
      check("rr_din", din1, 32'(((i % 4) + 1) * 16));
      check("rr_gid", gid1, 32'(i % 4));
      check("rr_busy", busy1, 0);
    end
    req1 = 4'b0100;
    #1; check("rr_extra_ack", ack1, 4'b0100);
    step();
    check("rr_extra_din", din1, 8'h30);
    req1 = '0;
    #1; check("rr_idle_ack", ack1, 0);
    step();
    check("rr_idle_push", push1, 0);
    check("rr_din_hold", din1, 8'h30);

`ifdef FIFO_ARB_STATS_EN
    stat_sel1 = 2'd2; #1; check("stat_p2", stat_cnt1, 3);
    stat_sel1 = 2'd0; #1; check("stat_p0", stat_cnt1, 2);
    check("stat_stall1", stall_cnt1, 0);
    stat_clr1 = 1'b1;
    step();
    stat_clr1 = 1'b0; stat_sel1 = 2'd2;
    #1; check("stat_clr", stat_cnt1, 0);
`endif

    // Burst lock, MAX_BURST=4: producer 1, then 2, then 1 again
    n1 = 0; n2 = 0;
    wdata4 = {8'h00, 8'h21, 8'h11, 8'h00};
    req4   = 4'b0110;
    for (int s = 0; s < 12; s++) begin
      p = burst_p[s];
      exp_d = (p == 1) ? 8'(8'h11 + n1) : 8'(8'h21 + n2);
      #1;
      check("burst_ack", ack4, 32'(1 << p));
      step();
      check("burst_push", push4, 1);
      check("burst_din", din4, exp_d);
      check("burst_gid", gid4, 32'(p));
      check("burst_busy", busy4, ((s % 4) != 3) ? 1 : 0);
      if (p == 1) n1++; else n2++;
      wdata4 = {8'h00, 8'(8'h21 + n2), 8'(8'h11 + n1), 8'h00};
      if (n2 == 4) req4[2] = 1'b0;
      if (n1 == 8) req4[1] = 1'b0;
    end
    #1; check("burst_end_ack", ack4, 0);
    step();
    check("burst_end_push", push4, 0);
    check("burst_end_busy", busy4, 0);

    // Backpressure: depth-4 FIFO, no pops, producer 0 streaming
    rst = 1'b1; req4 = '0;
    step();
    rst = 1'b0; model_on = 1'b1;
    n0 = 0; pushes = 0;
    wdata4 = {24'h0, 8'hA0};
    req4   = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      #1;
      check("bp_ack", ack4, (c < 4) ? 1 : 0);
      step();
      check("bp_push", push4, (c < 4) ? 1 : 0);
      check("bp_push_while_full", push4 && full4, 0);
      if (push4) pushes++;
      if (c < 4) begin
        check("bp_din", din4, 32'(8'hA0 + c));
        n0++;
        wdata4[7:0] = 8'(8'hA0 + n0);
      end
    end
    check("bp_push_total", pushes, 4);
`ifdef FIFO_ARB_STATS_EN
    check("bp_stall_cnt", stall_cnt4, 6);
`endif
    pop4 = 1'b1;
    #1; check("bp_pop_ack", ack4, 0);
    step();
    pop4 = 1'b0;
    #1; check("bp_resume_ack", ack4, 1);
    step();
    check("bp_resume_push", push4, 1);
    check("bp_resume_din", din4, 8'hA4);
    n0++;
    wdata4[7:0] = 8'(8'hA0 + n0);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("bp_refull_ack", ack4, 0);
      step();
      check("bp_refull_push", push4, 0);
      check("bp_refull_push_while_full", push4 && full4, 0);
    end

    // Early release: producer 3 drops after two words, pending 0 and 1
    rst = 1'b1; req4 = '0; model_on = 1'b0;
    step();
    rst = 1'b0;
    wdata4 = {8'h31, 8'h00, 8'h51, 8'h01};
    req4   = 4'b1000;
    #1; check("er_ack0", ack4, 4'b1000);
    step();
    check("er_din0", din4, 8'h31); check("er_busy0", busy4, 1); check("er_gid0", gid4, 3);
    wdata4[31:24] = 8'h32;
    req4 = 4'b1011;
    #1; check("er_ack1", ack4, 4'b1000);
    step();
    check("er_din1", din4, 8'h32); check("er_busy1", busy4, 1);
    req4 = 4'b0011;
    #1; check("er_release_ack", ack4, 0);
    step();
    check("er_release_busy", busy4, 0); check("er_release_push", push4, 0);
    check("er_din_hold", din4, 8'h32);
    #1; check("er_next_ack", ack4, 4'b0001);
    step();
    check("er_next_din", din4, 8'h01); check("er_next_gid", gid4, 0);
    check("er_next_busy", busy4, 1); check("er_next_push", push4, 1);

    // Reset with a push in flight and a burst open
    rst = 1'b1; req4 = '0;
    step();
    check("mrst_push", push4, 0); check("mrst_busy", busy4, 0);
    check("mrst_gid", gid4, 0); check("mrst_din", din4, 0);
    rst = 1'b0;
    #1; check("mrst_ack", ack4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
